// File: rtl/sam_rv32i_pkg.sv
// -----------------------------------------------------------------------------
// sam_rv32i_pkg
//   Shared types for the data-memory arbiter slice.
//   arb_state_t : arbiter FSM states (IDLE -> ISSUE -> WAIT -> DONE)
//   req_id_t    : requester identity (CORE = 0, HOST = 1)
//   LAT_W       : width of the memory-latency down-counter (MEM_LAT up to 7)
// -----------------------------------------------------------------------------
package sam_rv32i_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        CORE = 1'b0,
        HOST = 1'b1
    } req_id_t;

    localparam int LAT_W = 3;

endpackage

// File: rtl/sam_rr_pick2.sv
// -----------------------------------------------------------------------------
// sam_rr_pick2
//   Two-way combinational picker.
//   Ports:
//     req[1:0]      in  : request lines, bit 0 = CORE, bit 1 = HOST
//     last_winner   in  : requester that won the previous arbitration
//     prio_override in  : on a tie, force HOST to win
//     win_id        out : selected requester (only meaningful when any = 1)
//     any           out : at least one request is pending
//   A single request always wins. On a tie the requester that is not
//   last_winner wins, unless prio_override forces HOST.
// -----------------------------------------------------------------------------
module sam_rr_pick2
    import sam_rv32i_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last_winner,
    input  logic       prio_override,
    output req_id_t    win_id,
    output logic       any
);

    always_comb begin
        any    = |req;
        win_id = CORE;
        case (req)
            2'b01:   win_id = CORE;
            2'b10:   win_id = HOST;
            2'b11: begin
                if (prio_override) begin
                    win_id = HOST;
                end else if (last_winner == CORE) begin
                    win_id = HOST;
                end else begin
                    win_id = CORE;
                end
            end
            default: win_id = CORE;
        endcase
    end

endmodule

// File: rtl/sam_dm_arbiter.sv
// -----------------------------------------------------------------------------
// sam_dm_arbiter
//   Shares one single-port data memory between the pipeline MEM stage (core)
//   and a host loader/debug port. One access outstanding at a time; every
//   output is a register.
//
//   Ports:
//     clk, RN                        : clock (rising edge), async active-low reset
//     core_req/we/addr/wdata  (in)   : core command, req held until core_gnt
//     core_gnt, core_done     (out)  : 1-cycle accept / completion pulses
//     core_rdata              (out)  : read data, valid with core_done on reads,
//                                      held until the next core read completes
//     host_*                         : same set for the host port
//     mem_en/we/addr/wdata    (out)  : 1-cycle memory strobe plus command; the
//                                      command fields are 0 whenever mem_en = 0
//     mem_rdata               (in)   : sampled on the clock edge that closes
//                                      the MEM_LAT-th cycle, counting the
//                                      mem_en cycle as the first (MEM_LAT = 1
//                                      means an asynchronous-read memory)
//
//   Build option DM_ARB_CORE_PRIO_EN:
//     undefined : pure round-robin, core wins the first tie after reset.
//     defined   : core wins ties; after STARVE_MAX consecutive core grants
//                 with host_req high, the host wins the next tie.
// -----------------------------------------------------------------------------
module sam_dm_arbiter
    import sam_rv32i_pkg::*;
#(
    parameter int AW         = 5,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          RN,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_done,
    output logic [DW-1:0] core_rdata,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_done,
    output logic [DW-1:0] host_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    if (MEM_LAT < 1 || MEM_LAT > 7 || STARVE_MAX < 1) begin : g_bad_param
        $error("sam_dm_arbiter: MEM_LAT must be 1..7 and STARVE_MAX >= 1");
    end

    arb_state_t          state_q, state_d;
    req_id_t             win_q, win_d;
    logic                we_q, we_d;
    logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;

    logic                core_gnt_q, core_gnt_d;
    logic                core_done_q, core_done_d;
    logic [DW-1:0]       core_rdata_q, core_rdata_d;
    logic                host_gnt_q, host_gnt_d;
    logic                host_done_q, host_done_d;
    logic [DW-1:0]       host_rdata_q, host_rdata_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [AW-1:0]       mem_addr_q, mem_addr_d;
    logic [DW-1:0]       mem_wdata_q, mem_wdata_d;

    logic                enter_done;
    req_id_t             pick_win;
    logic                pick_any;
    req_id_t             pick_last;
    logic                pick_override;

`ifdef DM_ARB_CORE_PRIO_EN
    localparam int SC_W = $clog2(STARVE_MAX + 1);
    logic [SC_W-1:0]     starve_q, starve_d;

    // Core owns ties by presenting HOST as the previous winner; the
    // starvation counter flips the tie to the host once it saturates.
    assign pick_last     = HOST;
    assign pick_override = (starve_q == SC_W'(STARVE_MAX));
`else
    req_id_t             last_q, last_d;

    assign pick_last     = last_q;
    assign pick_override = 1'b0;
`endif

    sam_rr_pick2 u_pick (
        .req           ({host_req, core_req}),
        .last_winner   (pick_last),
        .prio_override (pick_override),
        .win_id        (pick_win),
        .any           (pick_any)
    );

    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        we_d         = we_q;
        lat_cnt_d    = lat_cnt_q;
        core_gnt_d   = 1'b0;
        core_done_d  = 1'b0;
        core_rdata_d = core_rdata_q;
        host_gnt_d   = 1'b0;
        host_done_d  = 1'b0;
        host_rdata_d = host_rdata_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        enter_done   = 1'b0;
`ifdef DM_ARB_CORE_PRIO_EN
        starve_d     = starve_q;
`else
        last_d       = last_q;
`endif

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    // The winner's command goes straight into the memory
                    // output registers so it appears in the ISSUE cycle.
                    state_d  = ISSUE;
                    win_d    = pick_win;
                    mem_en_d = 1'b1;
                    if (pick_win == HOST) begin
                        host_gnt_d  = 1'b1;
                        we_d        = host_we;
                        mem_we_d    = host_we;
                        mem_addr_d  = host_addr;
                        mem_wdata_d = host_wdata;
                    end else begin
                        core_gnt_d  = 1'b1;
                        we_d        = core_we;
                        mem_we_d    = core_we;
                        mem_addr_d  = core_addr;
                        mem_wdata_d = core_wdata;
                    end
`ifdef DM_ARB_CORE_PRIO_EN
                    if (pick_win == HOST || !host_req) begin
                        starve_d = '0;
                    end else if (starve_q != SC_W'(STARVE_MAX)) begin
                        starve_d = starve_q + 1'b1;
                    end
`endif
                end
            end
            ISSUE: begin
                lat_cnt_d = LAT_W'(MEM_LAT - 1);
                if (MEM_LAT == 1) begin
                    enter_done = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                lat_cnt_d = lat_cnt_q - LAT_W'(1);
                // Counter reaches zero on this edge: read data is valid now.
                if (lat_cnt_q == LAT_W'(1)) begin
                    enter_done = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
`ifndef DM_ARB_CORE_PRIO_EN
                last_d  = win_q;
`endif
            end
            default: state_d = IDLE;
        endcase

        // done and rdata are registered on the same edge so that rdata is
        // already valid during the DONE cycle.
        if (enter_done) begin
            state_d = DONE;
            if (win_q == HOST) begin
                host_done_d = 1'b1;
                if (!we_q) begin
                    host_rdata_d = mem_rdata;
                end
            end else begin
                core_done_d = 1'b1;
                if (!we_q) begin
                    core_rdata_d = mem_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            state_q      <= IDLE;
            win_q        <= CORE;
            we_q         <= 1'b0;
            lat_cnt_q    <= '0;
            core_gnt_q   <= 1'b0;
            core_done_q  <= 1'b0;
            core_rdata_q <= '0;
            host_gnt_q   <= 1'b0;
            host_done_q  <= 1'b0;
            host_rdata_q <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
`ifdef DM_ARB_CORE_PRIO_EN
            starve_q     <= '0;
`else
            last_q       <= HOST;
`endif
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            we_q         <= we_d;
            lat_cnt_q    <= lat_cnt_d;
            core_gnt_q   <= core_gnt_d;
            core_done_q  <= core_done_d;
            core_rdata_q <= core_rdata_d;
            host_gnt_q   <= host_gnt_d;
            host_done_q  <= host_done_d;
            host_rdata_q <= host_rdata_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
`ifdef DM_ARB_CORE_PRIO_EN
            starve_q     <= starve_d;
`else
            last_q       <= last_d;
`endif
        end
    end

    assign core_gnt   = core_gnt_q;
    assign core_done  = core_done_q;
    assign core_rdata = core_rdata_q;
    assign host_gnt   = host_gnt_q;
    assign host_done  = host_done_q;
    assign host_rdata = host_rdata_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_sam_dm_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sam_dm_arbiter
//   Two arbiter instances share clock and reset: index 0 uses MEM_LAT = 1,
//   index 1 uses MEM_LAT = 4. Each has its own memory model that returns
//   read data on the edge the arbiter samples it (a fill value otherwise).
//   Build option DM_ARB_CORE_PRIO_EN selects the expected tie order.
// -----------------------------------------------------------------------------
module tb_sam_dm_arbiter;

    localparam int NI = 2;
    localparam logic [31:0] FILL = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rn  = 1'b0;

    logic        core_req   [NI];
    logic        core_we    [NI];
    logic [4:0]  core_addr  [NI];
    logic [31:0] core_wdata [NI];
    logic        core_gnt   [NI];
    logic        core_done  [NI];
    logic [31:0] core_rdata [NI];
    logic        host_req   [NI];
    logic        host_we    [NI];
    logic [4:0]  host_addr  [NI];
    logic [31:0] host_wdata [NI];
    logic        host_gnt   [NI];
    logic        host_done  [NI];
    logic [31:0] host_rdata [NI];
    logic        mem_en     [NI];
    logic        mem_we     [NI];
    logic [4:0]  mem_addr   [NI];
    logic [31:0] mem_wdata  [NI];
    logic [31:0] mem_rdata  [NI];

    always #5 clk = ~clk;

    genvar gi;
    for (gi = 0; gi < NI; gi++) begin : g_dut
        localparam int LAT = (gi == 0) ? 1 : 4;
        logic [31:0] mem [32];
        logic [31:0] rd_now;
        logic [31:0] rd_pipe [4];

        sam_dm_arbiter #(
            .AW(5), .DW(32), .MEM_LAT(LAT), .STARVE_MAX(2)
        ) u_dut (
            .clk        (clk),
            .RN         (rn),
            .core_req   (core_req[gi]),
            .core_we    (core_we[gi]),
            .core_addr  (core_addr[gi]),
            .core_wdata (core_wdata[gi]),
            .core_gnt   (core_gnt[gi]),
            .core_done  (core_done[gi]),
            .core_rdata (core_rdata[gi]),
            .host_req   (host_req[gi]),
            .host_we    (host_we[gi]),
            .host_addr  (host_addr[gi]),
            .host_wdata (host_wdata[gi]),
            .host_gnt   (host_gnt[gi]),
            .host_done  (host_done[gi]),
            .host_rdata (host_rdata[gi]),
            .mem_en     (mem_en[gi]),
            .mem_we     (mem_we[gi]),
            .mem_addr   (mem_addr[gi]),
            .mem_wdata  (mem_wdata[gi]),
            .mem_rdata  (mem_rdata[gi])
        );

        // Asynchronous read during the mem_en cycle, then LAT-1 delay stages.
        assign rd_now = mem_en[gi] ? mem[mem_addr[gi]] : FILL;

        always @(posedge clk) begin
            if (mem_en[gi] && mem_we[gi]) mem[mem_addr[gi]] <= mem_wdata[gi];
            rd_pipe[0] <= rd_now;
            for (int k = 1; k < 4; k++) rd_pipe[k] <= rd_pipe[k-1];
        end

        if (LAT == 1) begin : g_l1
            assign mem_rdata[gi] = rd_now;
        end else begin : g_ln
            assign mem_rdata[gi] = rd_pipe[LAT-2];
        end
    end

    typedef struct {
        bit          host;
        bit          we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    int          gcount [NI];
    int          dcount [NI];
    int          menc   [NI];
    logic        gid    [NI][64];
    logic        did    [NI][64];
    int          dcyc   [NI][64];
    logic [31:0] exp_c  [NI];
    logic [31:0] exp_h  [NI];
    vec_t        vecs   [11];
    logic        exp_seq [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cyc++;
            for (int g = 0; g < NI; g++) begin
                if (core_gnt[g] || host_gnt[g]) begin
                    gid[g][gcount[g] % 64] = host_gnt[g];
                    gcount[g]++;
                end
                if (core_done[g] || host_done[g]) begin
                    did[g][dcount[g] % 64]  = host_done[g];
                    dcyc[g][dcount[g] % 64] = cyc;
                    dcount[g]++;
                end
                if (mem_en[g]) menc[g]++;
                else chk("mem_fields_idle", {26'd0, mem_we[g], mem_addr[g], mem_wdata[g]}, 64'd0);
                chk("gnt_onehot", {63'd0, core_gnt[g] & host_gnt[g]}, 64'd0);
                chk("done_onehot", {63'd0, core_done[g] & host_done[g]}, 64'd0);
            end
        end
    endtask

    task automatic clr_inputs();
        for (int g = 0; g < NI; g++) begin
            core_req[g] = 1'b0; core_we[g] = 1'b0; core_addr[g] = '0; core_wdata[g] = '0;
            host_req[g] = 1'b0; host_we[g] = 1'b0; host_addr[g] = '0; host_wdata[g] = '0;
        end
    endtask

    task automatic pulse_reset();
        rn = 1'b0;
        tick(2);
        rn = 1'b1;
        for (int g = 0; g < NI; g++) begin
            exp_c[g] = '0;
            exp_h[g] = '0;
        end
    endtask

    task automatic chk_reset_zero(input int g);
        chk("reset_ctl", {48'd0, core_gnt[g], core_done[g], host_gnt[g], host_done[g],
                          mem_en[g], mem_we[g], mem_addr[g], 5'd0}, 64'd0);
        chk("reset_wdata", {32'd0, mem_wdata[g]}, 64'd0);
        chk("reset_rdata", {core_rdata[g], host_rdata[g]}, 64'd0);
    endtask

    task automatic do_access(input int g, input vec_t v);
        int g0, d0, m0, n, lat;
        lat = (g == 0) ? 1 : 4;
        g0 = gcount[g]; d0 = dcount[g]; m0 = menc[g];
        if (v.host) begin
            host_req[g] = 1'b1; host_we[g] = v.we; host_addr[g] = v.addr; host_wdata[g] = v.wdata;
        end else begin
            core_req[g] = 1'b1; core_we[g] = v.we; core_addr[g] = v.addr; core_wdata[g] = v.wdata;
        end
        n = 0;
        while (gcount[g] == g0 && n < 10) begin
            tick(1);
            n++;
        end
        chk("gnt_latency", 64'(n), 64'd1);
        if (gcount[g] != g0) chk("gnt_id", {63'd0, gid[g][g0 % 64]}, {63'd0, v.host});
        core_req[g] = 1'b0;
        host_req[g] = 1'b0;
        n = 0;
        while (dcount[g] == d0 && n < 12) begin
            tick(1);
            n++;
        end
        chk("done_latency", 64'(n), 64'(lat));
        if (dcount[g] != d0) chk("done_id", {63'd0, did[g][d0 % 64]}, {63'd0, v.host});
        chk("mem_en_pulses", 64'(menc[g] - m0), 64'd1);
        if (!v.we) begin
            if (v.host) exp_h[g] = v.rdata;
            else        exp_c[g] = v.rdata;
        end
        chk("core_rdata", {32'd0, core_rdata[g]}, {32'd0, exp_c[g]});
        chk("host_rdata", {32'd0, host_rdata[g]}, {32'd0, exp_h[g]});
        $display("cyc=%0d inst=%0d %s %s addr=%0d wdata=%h core_rdata=%h host_rdata=%h",
                 cyc, g, v.host ? "HOST" : "CORE", v.we ? "WR" : "RD", v.addr, v.wdata,
                 core_rdata[g], host_rdata[g]);
        tick(1);
    endtask

    task automatic burst(input int g);
        int g0, d0, n, lat;
        lat = (g == 0) ? 1 : 4;
        pulse_reset();
        g0 = gcount[g]; d0 = dcount[g];
        core_req[g] = 1'b1; core_we[g] = 1'b1; core_addr[g] = 5'd1; core_wdata[g] = 32'h0000_0011;
        host_req[g] = 1'b1; host_we[g] = 1'b1; host_addr[g] = 5'd2; host_wdata[g] = 32'h0000_0022;
        n = 0;
        while (gcount[g] - g0 < 6 && n < 80) begin
            tick(1);
            n++;
        end
        core_req[g] = 1'b0;
        host_req[g] = 1'b0;
        chk("burst_grants", 64'(gcount[g] - g0), 64'd6);
        n = 0;
        while (dcount[g] - d0 < 6 && n < 20) begin
            tick(1);
            n++;
        end
        chk("burst_dones", 64'(dcount[g] - d0), 64'd6);
        for (int k = 0; k < 6; k++) begin
            chk("burst_order", {63'd0, gid[g][(g0 + k) % 64]}, {63'd0, exp_seq[k]});
            $display("cyc=%0d inst=%0d burst access %0d granted to %s", cyc, g, k,
                     gid[g][(g0 + k) % 64] ? "HOST" : "CORE");
        end
        for (int k = 1; k < 6; k++) begin
            chk("burst_spacing", 64'(dcyc[g][(d0 + k) % 64] - dcyc[g][(d0 + k - 1) % 64]),
                64'(lat + 2));
        end
        chk("burst_rdata", {core_rdata[g], host_rdata[g]}, 64'd0);
        tick(1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        //          host  we    addr   wdata          expected rdata
        vecs[0]  = '{1'b1, 1'b1, 5'd4,  32'd50,        32'd0};
        vecs[1]  = '{1'b0, 1'b0, 5'd4,  32'd0,         32'd50};
        vecs[2]  = '{1'b0, 1'b1, 5'd31, 32'hA5A5_0031, 32'd0};
        vecs[3]  = '{1'b1, 1'b0, 5'd31, 32'd0,         32'hA5A5_0031};
        vecs[4]  = '{1'b1, 1'b1, 5'd0,  32'h1234_5678, 32'd0};
        vecs[5]  = '{1'b0, 1'b0, 5'd0,  32'd0,         32'h1234_5678};
        vecs[6]  = '{1'b0, 1'b1, 5'd4,  32'hFFFF_FFFF, 32'd0};
        vecs[7]  = '{1'b1, 1'b0, 5'd4,  32'd0,         32'hFFFF_FFFF};
        vecs[8]  = '{1'b0, 1'b0, 5'd31, 32'd0,         32'hA5A5_0031};
        vecs[9]  = '{1'b1, 1'b1, 5'd31, 32'd0,         32'd0};
        vecs[10] = '{1'b1, 1'b0, 5'd31, 32'd0,         32'd0};
`ifdef DM_ARB_CORE_PRIO_EN
        exp_seq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`else
        exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
        for (int g = 0; g < NI; g++) begin
            gcount[g] = 0; dcount[g] = 0; menc[g] = 0;
            exp_c[g] = '0; exp_h[g] = '0;
        end
        clr_inputs();

        // Reset held with both requests high: everything stays 0, then the
        // core wins the first tie and completes MEM_LAT cycles after gnt.
        rn = 1'b0;
        for (int g = 0; g < NI; g++) begin
            core_req[g] = 1'b1; core_addr[g] = 5'd3;
            host_req[g] = 1'b1; host_addr[g] = 5'd5;
        end
        tick(3);
        for (int g = 0; g < NI; g++) chk_reset_zero(g);
        rn = 1'b1;
        tick(1);
        for (int g = 0; g < NI; g++) begin
            chk("first_gnt_core", {62'd0, core_gnt[g], host_gnt[g]}, 64'd2);
        end
        clr_inputs();
        tick(1);
        chk("lat1_core_done", {63'd0, core_done[0]}, 64'd1);
        chk("lat4_no_done_yet", {63'd0, core_done[1]}, 64'd0);
        tick(3);
        chk("lat4_core_done", {63'd0, core_done[1]}, 64'd1);
        $display("cyc=%0d reset-release core read done on both instances", cyc);
        tick(2);

        // Single-requester accesses from the vector table.
        for (int g = 0; g < NI; g++) begin
            pulse_reset();
            for (int i = 0; i < 11; i++) do_access(g, vecs[i]);
        end

        // Both requests held for six accesses.
        for (int g = 0; g < NI; g++) burst(g);

        // Reset dropped while instance 1 waits on memory: access abandoned.
        pulse_reset();
        d0 = dcount[1];
        core_req[1] = 1'b1; core_we[1] = 1'b0; core_addr[1] = 5'd31;
        tick(1);
        chk("abort_gnt", {63'd0, core_gnt[1]}, 64'd1);
        core_req[1] = 1'b0;
        tick(1);
        rn = 1'b0;
        tick(2);
        chk_reset_zero(1);
        rn = 1'b1;
        for (int g = 0; g < NI; g++) begin
            exp_c[g] = '0;
            exp_h[g] = '0;
        end
        tick(8);
        chk("abort_no_done", 64'(dcount[1] - d0), 64'd0);
        $display("cyc=%0d inst=1 access abandoned by reset", cyc);
        do_access(1, '{1'b1, 1'b1, 5'd7, 32'd77, 32'd0});
        do_access(1, '{1'b0, 1'b0, 5'd7, 32'd0,  32'd77});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
